// File: rtl/vdf_iteration_controller.sv
// rtl/vdf_iteration_controller.sv - sequences one VDF evaluation on the modular squarer:
// load, count T squarings, flush, and hand back the result (with abort and stall watchdog).
module vdf_iteration_controller #(
    parameter int MOD_LEN            = 1024,
    parameter int WORD_LEN           = 16,
    parameter int REDUNDANT_ELEMENTS = 2,
    parameter int NUM_ELEMENTS       = MOD_LEN / WORD_LEN + REDUNDANT_ELEMENTS,
    parameter int SQ_OUT_BITS        = NUM_ELEMENTS * WORD_LEN * 2,
    parameter int ITER_W             = 64,
    parameter int FLUSH_CYCLES       = 8,
    parameter int TIMEOUT_CYCLES     = 1024
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   job_valid,
    output logic                   job_ready,
    input  logic [MOD_LEN-1:0]     job_sq_in,
    input  logic [ITER_W-1:0]      job_iters,
    input  logic                   abort,
    output logic                   sq_start,
    output logic [MOD_LEN-1:0]     sq_in,
    output logic                   sq_reset,
    input  logic                   sq_valid,
    input  logic [SQ_OUT_BITS-1:0] sq_out,
    output logic                   res_valid,
    input  logic                   res_ready,
    output logic [SQ_OUT_BITS-1:0] res_sq_out,
    output logic [ITER_W-1:0]      res_iters,
    output logic [1:0]             res_status,
    output logic                   busy,
    output logic [ITER_W-1:0]      iter_count
);

    localparam int LANE_W    = 2 * WORD_LEN;
    localparam int NUM_WORDS = MOD_LEN / WORD_LEN;
    localparam int TO_W      = $clog2(TIMEOUT_CYCLES + 1);
    localparam int FL_W      = $clog2(FLUSH_CYCLES + 1);

    localparam logic [1:0] STATUS_OK      = 2'd0;
    localparam logic [1:0] STATUS_TIMEOUT = 2'd1;
    localparam logic [1:0] STATUS_ABORTED = 2'd2;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LOAD,
        ST_RUN,
        ST_FLUSH,
        ST_DONE
    } state_t;

    state_t state;
    state_t state_next;

    logic [ITER_W-1:0]      iters_target;
    logic [TO_W-1:0]        timeout_cnt;
    logic [FL_W-1:0]        flush_cnt;
    logic [SQ_OUT_BITS-1:0] seed_lanes;
    logic [ITER_W-1:0]      count_next;
    logic                   final_hit;
    logic                   timeout_hit;
    logic                   flush_last;

    logic accept;
    logic count_en;
    logic end_ok;
    logic end_abort;
    logic end_timeout;

    // A T==0 job returns the seed itself, laid out like a squarer result:
    // one zero-extended word per 2*WORD_LEN lane, redundant lanes left at zero.
    always_comb begin
        seed_lanes = '0;
        for (int j = 0; j < NUM_WORDS; j++) begin
            seed_lanes[j*LANE_W +: LANE_W] = {{WORD_LEN{1'b0}}, job_sq_in[j*WORD_LEN +: WORD_LEN]};
        end
    end

    // The count saturates; the final-iteration compare is one bit wider so a
    // saturated count can never alias onto a small T.
    assign count_next  = (iter_count == {ITER_W{1'b1}}) ? iter_count : iter_count + 1'b1;
    assign final_hit   = ({1'b0, iter_count} + {{ITER_W{1'b0}}, 1'b1}) == {1'b0, iters_target};
    assign timeout_hit = (timeout_cnt == TO_W'(TIMEOUT_CYCLES - 1));
    assign flush_last  = (flush_cnt == FL_W'(FLUSH_CYCLES - 1));

    always_comb begin
        state_next  = state;
        job_ready   = 1'b0;
        sq_start    = 1'b0;
        sq_reset    = 1'b0;
        res_valid   = 1'b0;
        busy        = 1'b1;
        accept      = 1'b0;
        count_en    = 1'b0;
        end_ok      = 1'b0;
        end_abort   = 1'b0;
        end_timeout = 1'b0;
        case (state)
            ST_IDLE: begin
                job_ready = 1'b1;
                busy      = 1'b0;
                if (job_valid) begin
                    accept     = 1'b1;
                    state_next = (job_iters == '0) ? ST_DONE : ST_LOAD;
                end
            end
            ST_LOAD: begin
                sq_start = 1'b1;
                if (abort) begin
                    end_abort  = 1'b1;
                    state_next = ST_FLUSH;
                end else begin
                    state_next = ST_RUN;
                end
            end
            ST_RUN: begin
                // final result beats abort, abort beats the watchdog
                count_en = sq_valid;
                if (sq_valid && final_hit) begin
                    end_ok     = 1'b1;
                    state_next = ST_FLUSH;
                end else if (abort) begin
                    end_abort  = 1'b1;
                    state_next = ST_FLUSH;
                end else if (!sq_valid && timeout_hit) begin
                    end_timeout = 1'b1;
                    state_next  = ST_FLUSH;
                end
            end
            ST_FLUSH: begin
                sq_reset = 1'b1;
                if (flush_last) begin
                    state_next = ST_DONE;
                end
            end
            ST_DONE: begin
                res_valid = 1'b1;
                if (res_ready) begin
                    state_next = ST_IDLE;
                end
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state        <= ST_IDLE;
            sq_in        <= '0;
            iters_target <= '0;
            iter_count   <= '0;
            res_sq_out   <= '0;
            res_iters    <= '0;
            res_status   <= STATUS_OK;
            timeout_cnt  <= '0;
            flush_cnt    <= '0;
        end else begin
            state <= state_next;

            if (accept) begin
                sq_in        <= job_sq_in;
                iters_target <= job_iters;
                iter_count   <= '0;
                res_iters    <= '0;
                res_status   <= STATUS_OK;
                res_sq_out   <= (job_iters == '0) ? seed_lanes : '0;
            end

            if (count_en) begin
                iter_count <= count_next;
                res_sq_out <= sq_out;
            end

            // Held at zero outside RUN so every RUN entry starts a fresh window.
            if (state != ST_RUN || sq_valid) begin
                timeout_cnt <= '0;
            end else if (!timeout_hit) begin
                timeout_cnt <= timeout_cnt + 1'b1;
            end

            if (state != ST_FLUSH) begin
                flush_cnt <= '0;
            end else if (!flush_last) begin
                flush_cnt <= flush_cnt + 1'b1;
            end

            if (end_ok) begin
                res_iters  <= count_next;
                res_status <= STATUS_OK;
            end else if (end_abort) begin
                res_iters  <= count_en ? count_next : iter_count;
                res_status <= STATUS_ABORTED;
            end else if (end_timeout) begin
                res_iters  <= iter_count;
                res_status <= STATUS_TIMEOUT;
            end
        end
    end

endmodule

// File: tb/tb_vdf_iteration_controller.sv
// tb/tb_vdf_iteration_controller.sv - randomized job bench for vdf_iteration_controller
// with a result-level reference model.
module tb_vdf_iteration_controller;

    localparam int MOD_LEN        = 1024;
    localparam int WORD_LEN       = 16;
    localparam int NUM_ELEMENTS   = MOD_LEN / WORD_LEN + 2;
    localparam int SQ_OUT_BITS    = NUM_ELEMENTS * WORD_LEN * 2;
    localparam int ITER_W         = 64;
    localparam int FLUSH_CYCLES   = 8;
    localparam int TIMEOUT_CYCLES = 1024;
    localparam int LANE_W         = 2 * WORD_LEN;
    localparam int WAIT_BOUND     = TIMEOUT_CYCLES + FLUSH_CYCLES + 64;

    logic                   clk = 1'b0;
    logic                   reset;
    logic                   job_valid;
    logic                   job_ready;
    logic [MOD_LEN-1:0]     job_sq_in;
    logic [ITER_W-1:0]      job_iters;
    logic                   abort;
    logic                   sq_start;
    logic [MOD_LEN-1:0]     sq_in;
    logic                   sq_reset;
    logic                   sq_valid;
    logic [SQ_OUT_BITS-1:0] sq_out;
    logic                   res_valid;
    logic                   res_ready;
    logic [SQ_OUT_BITS-1:0] res_sq_out;
    logic [ITER_W-1:0]      res_iters;
    logic [1:0]             res_status;
    logic                   busy;
    logic [ITER_W-1:0]      iter_count;

    int n_cmp   = 0;
    int n_bad   = 0;
    int n_start = 0;
    int n_reset = 0;

    vdf_iteration_controller #(
        .MOD_LEN(MOD_LEN), .WORD_LEN(WORD_LEN), .REDUNDANT_ELEMENTS(2),
        .ITER_W(ITER_W), .FLUSH_CYCLES(FLUSH_CYCLES), .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) dut (
        .clk(clk), .reset(reset),
        .job_valid(job_valid), .job_ready(job_ready), .job_sq_in(job_sq_in), .job_iters(job_iters),
        .abort(abort),
        .sq_start(sq_start), .sq_in(sq_in), .sq_reset(sq_reset), .sq_valid(sq_valid), .sq_out(sq_out),
        .res_valid(res_valid), .res_ready(res_ready), .res_sq_out(res_sq_out),
        .res_iters(res_iters), .res_status(res_status),
        .busy(busy), .iter_count(iter_count)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (sq_start) n_start <= n_start + 1;
        if (sq_reset) n_reset <= n_reset + 1;
    end

    initial begin
        #900000;
        $display("FAIL watchdog: simulation time limit reached, got no finish, expected finish");
        $fatal(1);
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [MOD_LEN-1:0] rand_mod();
        logic [MOD_LEN-1:0] r;
        for (int i = 0; i < MOD_LEN / 32; i++) r[i*32 +: 32] = $urandom;
        return r;
    endfunction

    function automatic logic [SQ_OUT_BITS-1:0] rand_out();
        logic [SQ_OUT_BITS-1:0] r;
        for (int i = 0; i < SQ_OUT_BITS / 32; i++) r[i*32 +: 32] = $urandom;
        return r;
    endfunction

    function automatic logic [SQ_OUT_BITS-1:0] expand(input logic [MOD_LEN-1:0] v);
        logic [SQ_OUT_BITS-1:0] r;
        r = '0;
        for (int j = 0; j < MOD_LEN / WORD_LEN; j++) r[j*LANE_W +: LANE_W] = LANE_W'(v[j*WORD_LEN +: WORD_LEN]);
        return r;
    endfunction

    // t: iteration count; s: valids before the squarer stalls (-1 never);
    // a: valids before abort (-1 never), same: abort rides on the a-th valid.
    task automatic run_job(input logic [MOD_LEN-1:0] v, input int t, input int s, input int a,
                           input bit same, input int gap, input int hold);
        logic [SQ_OUT_BITS-1:0] outs[$];
        logic [SQ_OUT_BITS-1:0] exp_res;
        int nv, exp_status, starts0, resets0, lat, rst_lat, g;
        bit same_v;
        same_v = same && (a >= 1);
        if (t == 0) begin
            exp_res = expand(v);
            nv = 0;
            exp_status = 0;
        end else begin
            nv = t;
            if (s >= 0 && s < nv) nv = s;
            if (a >= 0 && a < nv) nv = a;
            for (int k = 0; k < nv; k++) outs.push_back(rand_out());
            if (nv == t) exp_status = 0;
            else if (a >= 0 && a == nv) exp_status = 2;
            else exp_status = 1;
            exp_res = (nv == 0) ? '0 : outs[nv-1];
        end

        starts0 = n_start;
        resets0 = n_reset;
        job_sq_in = v;
        job_iters = 64'(t);
        job_valid = 1'b1;
        check("job_ready_idle", 64'(job_ready), 64'd1);
        step();
        job_valid = 1'b0;
        job_sq_in = rand_mod();
        job_iters = 64'($urandom);
        lat = 0;
        rst_lat = 0;
        if (t != 0) begin
            check("sq_start_after_accept", 64'(sq_start), 64'd1);
            check("sq_in_latched", 64'(sq_in == v), 64'd1);
            sq_valid = 1'($urandom_range(0, 1));
            sq_out = rand_out();
            abort = (a == 0);
            step();
            sq_valid = 1'b0;
            abort = 1'b0;
            for (int k = 1; k <= nv; k++) begin
                g = (gap >= 0) ? gap : int'($urandom_range(0, 4));
                repeat (g) step();
                sq_valid = 1'b1;
                sq_out = outs[k-1];
                abort = same_v && (k == a);
                step();
                sq_valid = 1'b0;
                abort = 1'b0;
                lat = 1;
                check("iter_count_live", iter_count, 64'(k));
            end
            if (a >= 1 && !same_v && a == nv) begin
                abort = 1'b1;
                step();
                abort = 1'b0;
                lat++;
            end
        end

        while (!res_valid && lat < WAIT_BOUND) begin
            if (sq_reset && rst_lat == 0) rst_lat = lat;
            sq_valid = sq_reset ? 1'($urandom_range(0, 1)) : 1'b0;
            sq_out = rand_out();
            step();
            lat++;
        end
        sq_valid = 1'b0;

        check("res_valid_seen", 64'(res_valid), 64'd1);
        if (t != 0 && exp_status == 0) check("final_to_res_latency", 64'(lat), 64'(FLUSH_CYCLES + 1));
        if (exp_status == 1) check("timeout_latency", 64'(rst_lat), 64'(TIMEOUT_CYCLES + 1));
        check("res_status", 64'(res_status), 64'(exp_status));
        check("res_iters", res_iters, 64'(nv));
        for (int j = 0; j < NUM_ELEMENTS; j++)
            check($sformatf("res_lane%0d", j), 64'(res_sq_out[j*LANE_W +: LANE_W]), 64'(exp_res[j*LANE_W +: LANE_W]));
        check("sq_start_pulses", 64'(n_start - starts0), (t != 0) ? 64'd1 : 64'd0);
        check("sq_reset_cycles", 64'(n_reset - resets0), (t != 0) ? 64'(FLUSH_CYCLES) : 64'd0);
        check("job_ready_in_done", 64'(job_ready), 64'd0);
        check("busy_in_done", 64'(busy), 64'd1);

        for (int h = 0; h < hold; h++) begin
            res_ready = 1'b0;
            step();
            check("hold_res_valid", 64'(res_valid), 64'd1);
            check("hold_res_stable", 64'(res_sq_out == exp_res && res_iters == 64'(nv)
                                         && res_status == 2'(exp_status)), 64'd1);
            check("hold_job_ready", 64'(job_ready), 64'd0);
        end
        res_ready = 1'b1;
        step();
        res_ready = 1'b0;
        check("released_res_valid", 64'(res_valid), 64'd0);
        check("released_job_ready", 64'(job_ready), 64'd1);
        check("released_busy", 64'(busy), 64'd0);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_job_ready"}, 64'(job_ready), 64'd1);
        check({tag, "_zero_outputs"}, 64'({sq_start, sq_reset, res_valid, busy, res_status} == '0
                                          && iter_count == '0 && res_iters == '0
                                          && sq_in == '0 && res_sq_out == '0), 64'd1);
    endtask

    initial begin
        logic [MOD_LEN-1:0] v;
        int t, s, a, mode;
        bit same;
        reset = 1'b1;
        job_valid = 1'b0;
        job_sq_in = '0;
        job_iters = '0;
        abort = 1'b0;
        sq_valid = 1'b0;
        sq_out = '0;
        res_ready = 1'b0;
        #3;
        check_reset_outputs("por");
        repeat (2) step();
        reset = 1'b0;
        step();

        v = rand_mod();
        v[15:0] = 16'h1234;
        run_job(v, 0, -1, -1, 1'b0, -1, 2);
        run_job(rand_mod(), 3, -1, -1, 1'b0, 9, 0);
        run_job(rand_mod(), 5, -1, 2, 1'b0, -1, 1);
        run_job(rand_mod(), 4, 1, -1, 1'b0, -1, 0);
        run_job(rand_mod(), 2, -1, 2, 1'b1, -1, 20);

        job_sq_in = rand_mod();
        job_iters = 64'd5;
        job_valid = 1'b1;
        step();
        job_valid = 1'b0;
        step();
        sq_valid = 1'b1;
        sq_out = rand_out();
        step();
        sq_valid = 1'b0;
        step();
        check("midrun_iter_count", iter_count, 64'd1);
        #2;
        reset = 1'b1;
        #1;
        check_reset_outputs("midrun_reset");
        @(posedge clk);
        #1;
        reset = 1'b0;
        step();
        run_job(rand_mod(), 1, -1, -1, 1'b0, -1, 1);

        for (int j = 0; j < 24; j++) begin
            t = $urandom_range(0, 6);
            mode = $urandom_range(0, 9);
            s = -1;
            a = -1;
            same = 1'b0;
            if (mode == 0 && t >= 2) begin
                s = $urandom_range(1, t - 1);
            end else if (mode <= 4 && t >= 1) begin
                a = $urandom_range(0, t);
                same = 1'($urandom_range(0, 1));
            end
            run_job(rand_mod(), t, s, a, same, -1, $urandom_range(0, 3));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/vdf_iteration_controller.md
Name: vdf_iteration_controller

Overview:
Sequences the modular squaring datapath for one VDF evaluation.
- Accepts a job: a starting value plus an iteration count T.
- Loads the value into the squarer, pulses start, then counts the squarer's valid pulses.
- On the T-th result it captures the output, flushes the squarer with a reset window and returns the result through a valid/ready handshake.
- Sits between the host/job interface and the squarer wrapper; also handles abort and a stall watchdog.

Parameters:
- MOD_LEN, 1024, modulus width in bits.
- WORD_LEN, 16, coefficient word width.
- REDUNDANT_ELEMENTS, 2, extra redundant coefficients.
- NUM_ELEMENTS, MOD_LEN/WORD_LEN+REDUNDANT_ELEMENTS, total coefficients.
- SQ_OUT_BITS, NUM_ELEMENTS*WORD_LEN*2, squarer output width (32-bit lane per coefficient).
- ITER_W, 64, iteration counter width.
- FLUSH_CYCLES, 8, cycles sq_reset is held after a job ends (must be ≥1).
- TIMEOUT_CYCLES, 1024, maximum cycles between sq_valid pulses in RUN.

Ports:
- clk  in  1  clock
- reset  in  1  asynchronous, active-high reset
- job_valid  in  1  job offered
- job_ready  out  1  controller can accept a job
- job_sq_in  in  MOD_LEN  starting value
- job_iters  in  ITER_W  iteration count T
- abort  in  1  level; cancels the running job
- sq_start  out  1  one-cycle start pulse to the squarer
- sq_in  out  MOD_LEN  value presented to the squarer
- sq_reset  out  1  squarer flush reset
- sq_valid  in  1  squarer produced one iteration
- sq_out  in  SQ_OUT_BITS  squarer result
- res_valid  out  1  result available
- res_ready  in  1  result consumed
- res_sq_out  out  SQ_OUT_BITS  captured result
- res_iters  out  ITER_W  iterations completed for this result
- res_status  out  2  0=ok, 1=timeout, 2=aborted
- busy  out  1  state != IDLE
- iter_count  out  ITER_W  live count of valids in the current job

Behaviour:
- Reset (async, active-high): state=IDLE. All outputs and internal registers are 0, except job_ready=1 because it is decoded from IDLE.
- States and transitions:
  - IDLE: job_ready=1.
    - On job_valid&&job_ready: latch job_sq_in into sq_in, latch T, clear iter_count/res regs/status.
    - If T==0: go to DONE. res_sq_out = job_sq_in with word j zero-extended into lane j; redundant lanes 0; res_iters=0; status 0. The squarer is untouched.
    - Otherwise: go to LOAD.
  - LOAD: 1 cycle. sq_start=1; next state RUN. sq_in holds its value from accept until the job returns to IDLE.
  - RUN: each sq_valid increments iter_count and loads sq_out into res_sq_out; the timeout counter clears.
    - When sq_valid arrives with iter_count+1==T: go to FLUSH, status 0.
    - Timeout counter also clears on RUN entry. When it reaches TIMEOUT_CYCLES-1 without sq_valid: go to FLUSH, status 1.
  - FLUSH: sq_reset=1 for exactly FLUSH_CYCLES cycles, then DONE.
  - DONE: res_valid=1. res_* outputs are stable until res_valid&&res_ready, which returns the block to IDLE; job_ready=1 the next cycle.
- Abort:
  - abort in LOAD or RUN: go to FLUSH, status 2. res_sq_out holds the last captured value and res_iters = iter_count.
  - abort in IDLE, FLUSH or DONE is ignored.
- Priority in one RUN cycle: final sq_valid > abort > timeout. A non-final sq_valid coinciding with abort is still counted and captured, then abort applies.
- sq_valid outside RUN is ignored; no count and no capture.
- iter_count saturates at 2^ITER_W-1; it never wraps.
- res_iters equals iter_count at FLUSH entry.
- Latencies:
  - Accept to sq_start: 1 cycle.
  - Final sq_valid to res_valid: FLUSH_CYCLES+1 cycles.
  - T==0 accept to res_valid: 1 cycle.
- Reset mid-job: immediate return to IDLE; any pending result is discarded.

Test Plan:
- T=0, job_sq_in word0=0x1234 -> res_valid on the cycle after accept; lane0=0x00001234; res_iters=0; status 0; sq_start never asserted.
- T=3, squarer model asserts sq_valid every 10 cycles -> exactly one sq_start. res_sq_out equals the 3rd sq_out; res_iters=3; status 0. sq_reset high for 8 cycles, then res_valid.
- T=5, abort asserted after the 2nd valid -> FLUSH, status 2, res_iters=2, res_sq_out = 2nd sq_out.
- T=4, squarer stalls after 1 valid -> timeout after 1024 idle cycles; status 1; res_iters=1.
- T=2 with abort on the same cycle as the 2nd valid -> status 0, res_iters=2. Hold res_ready=0 for 20 cycles -> res_* stable and job_ready=0 throughout.
- Async reset mid-RUN -> all outputs 0 and job_ready=1 immediately. A new job with T=1 then completes with status 0.
